// File: rtl/conv_pkg.sv
// Shared constants and pixel/row types for the conv_top datapath.
// Row words are packed pixel vectors, pixel 0 in the least significant bits.
package conv_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int WH             = 2;
  localparam int IW             = 7;
  localparam int ROW_FIFO_DEPTH = 16;

  typedef logic [DATA_WIDTH-1:0] pix_t;
  typedef pix_t [IW-1:0]         row_t;

endpackage

// File: rtl/pe_row_fifo_tx_if.sv
// PE-to-row-buffer link: tile write side from the PE array, per-lane pop side
// from the row buffer. The FIFO block uses the slave modport.
interface pe_row_fifo_tx_if #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int Wh         = conv_pkg::WH,
  parameter int Iw         = conv_pkg::IW
);

  logic [Wh*Iw*DATA_WIDTH-1:0] pe_din;
  logic                        pe_wr_en;
  logic                        pe_full;
  logic [Wh-1:0]               pe2row_fifo_array1_rden;
  logic                        pe2row_ready;
  logic [Wh*Iw*DATA_WIDTH-1:0] fifo_array1_dataout;
  logic                        pe2row_data_valid;
  logic                        err_sticky;

  modport master (
    output pe_din, pe_wr_en, pe2row_fifo_array1_rden, pe2row_ready,
    input  pe_full, fifo_array1_dataout, pe2row_data_valid, err_sticky
  );

  modport slave (
    input  pe_din, pe_wr_en, pe2row_fifo_array1_rden, pe2row_ready,
    output pe_full, fifo_array1_dataout, pe2row_data_valid, err_sticky
  );

endinterface

// File: rtl/row_fifo.sv
// Single-lane first-word-fall-through FIFO; dout is the raw memory word at the
// read pointer, so callers mask it with empty. Memory itself is never reset.
module row_fifo
  import conv_pkg::*;
#(
  parameter type word_t = row_t,
  parameter int  DEPTH  = ROW_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  word_t                    din,
  input  logic                     rd_en,
  output word_t                    dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     empty,
  output logic                     full
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_wr, do_rd;
  word_t            mem [DEPTH];

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign dout  = mem[rd_ptr_q];

  // A pop never frees room for a write in the same cycle, and a write into an
  // empty lane cannot be popped before it has been seen on dout.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q;
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!do_wr && do_rd) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pe_row_fifo_tx.sv
// PE-side transmit end of the PE-to-row-buffer link: one FWFT FIFO per row lane.
// Define PE_ROW_FIFO_ERR_CHECK_EN to latch overflow/underflow attempts on err_sticky.
module pe_row_fifo_tx #(
  parameter int DATA_WIDTH = conv_pkg::DATA_WIDTH,
  parameter int Wh         = conv_pkg::WH,
  parameter int Iw         = conv_pkg::IW,
  parameter int DEPTH      = conv_pkg::ROW_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  pe_row_fifo_tx_if.slave bus
);

  import conv_pkg::*;

  localparam int RW = Iw * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);

  typedef logic [RW-1:0] lane_word_t;

  logic             pe_full;
  logic             write_accept;
  logic [Wh-1:0]    lane_full;
  logic [Wh-1:0]    lane_empty;
  logic [Wh-1:0]    lane_has_data;
  logic [Wh-1:0]    lane_pop;
  lane_word_t       lane_head [Wh];
  logic [Wh*RW-1:0] dataout_flat;

  // Tiles are all-or-nothing: one full lane blocks every lane.
  assign pe_full      = |lane_full;
  assign write_accept = bus.pe_wr_en && !pe_full;

  generate
    for (genvar gi = 0; gi < Wh; gi++) begin : g_lane
      logic [AW:0] lane_cnt;

      assign lane_pop[gi] = bus.pe2row_fifo_array1_rden[gi] && bus.pe2row_ready;

      row_fifo #(
        .word_t (lane_word_t),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (write_accept),
        .din   (bus.pe_din[gi*RW +: RW]),
        .rd_en (lane_pop[gi]),
        .dout  (lane_head[gi]),
        .cnt   (lane_cnt),
        .empty (lane_empty[gi]),
        .full  (lane_full[gi])
      );

      assign lane_has_data[gi]          = (lane_cnt != '0);
      assign dataout_flat[gi*RW +: RW]  = lane_empty[gi] ? '0 : lane_head[gi];
    end
  endgenerate

  assign bus.pe_full             = pe_full;
  assign bus.pe2row_data_valid   = &lane_has_data;
  assign bus.fifo_array1_dataout = dataout_flat;

`ifdef PE_ROW_FIFO_ERR_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((bus.pe_wr_en && pe_full) || |(lane_pop & lane_empty)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_sticky = err_q;
`else
  assign bus.err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pe_row_fifo_tx.sv
// Self-checking bench for pe_row_fifo_tx against a per-lane queue model.
// Honours PE_ROW_FIFO_ERR_CHECK_EN for the expected err_sticky behaviour.
module tb_pe_row_fifo_tx;

  localparam int DW    = conv_pkg::DATA_WIDTH;
  localparam int WH    = conv_pkg::WH;
  localparam int IW    = conv_pkg::IW;
  localparam int DEPTH = conv_pkg::ROW_FIFO_DEPTH;
  localparam int RW    = IW * DW;
  localparam int TW    = WH * RW;

  typedef logic [RW-1:0] word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  word_t mq [WH][$];
  logic  m_err = 1'b0;

  pe_row_fifo_tx_if #(.DATA_WIDTH(DW), .Wh(WH), .Iw(IW)) bus ();

  pe_row_fifo_tx #(.DATA_WIDTH(DW), .Wh(WH), .Iw(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int i = 0; i < WH * IW; i++) t[i*DW +: DW] = DW'($urandom);
    return t;
  endfunction

  // Lane r pixel p = base[r] + p (lane0 base b0, lane1 base b1).
  function automatic logic [TW-1:0] seq_tile(input int b0, input int b1);
    logic [TW-1:0] t;
    t = '0;
    for (int p = 0; p < IW; p++) begin
      t[p*DW +: DW]        = DW'(b0 + p);
      t[(IW+p)*DW +: DW]   = DW'(b1 + p);
    end
    return t;
  endfunction

  task automatic check(input string tag);
    logic [TW-1:0] exp_d;
    logic exp_v, exp_f;
    exp_d = '0;
    exp_v = 1'b1;
    exp_f = 1'b0;
    for (int i = 0; i < WH; i++) begin
      if (mq[i].size() == 0) exp_v = 1'b0;
      else exp_d[i*RW +: RW] = mq[i][0];
      if (mq[i].size() == DEPTH) exp_f = 1'b1;
    end
    checks++;
    assert (bus.pe_full === exp_f) else begin
      failures++;
      $error("FAIL %s pe_full got=%0b exp=%0b", tag, bus.pe_full, exp_f);
    end
    checks++;
    assert (bus.pe2row_data_valid === exp_v) else begin
      failures++;
      $error("FAIL %s data_valid got=%0b exp=%0b", tag, bus.pe2row_data_valid, exp_v);
    end
    checks++;
    assert (bus.fifo_array1_dataout === exp_d) else begin
      failures++;
      $error("FAIL %s dataout got=%h exp=%h", tag, bus.fifo_array1_dataout, exp_d);
    end
    checks++;
    assert (bus.err_sticky === m_err) else begin
      failures++;
      $error("FAIL %s err_sticky got=%0b exp=%0b", tag, bus.err_sticky, m_err);
    end
  endtask

  task automatic expect_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check at edge+1.
  task automatic step(input string tag, input logic rs, input logic w,
                      input logic [TW-1:0] d, input logic [WH-1:0] rd, input logic rdy);
    logic full_now, under;
    logic [WH-1:0] pop;
    rst = rs;
    bus.pe_wr_en = w;
    bus.pe_din = d;
    bus.pe2row_fifo_array1_rden = rd;
    bus.pe2row_ready = rdy;
    full_now = 1'b0;
    under = 1'b0;
    for (int i = 0; i < WH; i++) begin
      if (mq[i].size() == DEPTH) full_now = 1'b1;
      pop[i] = rd[i] && rdy && (mq[i].size() != 0);
      if (rd[i] && rdy && (mq[i].size() == 0)) under = 1'b1;
    end
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < WH; i++) mq[i].delete();
      m_err = 1'b0;
    end else begin
`ifdef PE_ROW_FIFO_ERR_CHECK_EN
      if ((w && full_now) || under) m_err = 1'b1;
`endif
      for (int i = 0; i < WH; i++) if (pop[i]) void'(mq[i].pop_front());
      if (w && !full_now)
        for (int i = 0; i < WH; i++) mq[i].push_back(d[i*RW +: RW]);
    end
    #1;
    check(tag);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < DEPTH + 2; n++) step(tag, 1'b0, 1'b0, '0, '1, 1'b1);
  endtask

  initial begin
    bus.pe_wr_en = 1'b0;
    bus.pe_din = '0;
    bus.pe2row_fifo_array1_rden = '0;
    bus.pe2row_ready = 1'b0;

    step("reset0", 1'b1, 1'b0, '0, '0, 1'b0);
    step("reset1", 1'b1, 1'b0, '0, '0, 1'b0);
    step("idle", 1'b0, 1'b0, '0, '0, 1'b0);

    step("first_tile", 1'b0, 1'b1, seq_tile(1, 11), '0, 1'b0);
    expect_bit("first_valid", bus.pe2row_data_valid, 1'b1);
    drain("drain_first");

    for (int n = 0; n < DEPTH; n++) step("fill", 1'b0, 1'b1, rand_tile(), '0, 1'b1);
    expect_bit("full_after_16", bus.pe_full, 1'b1);
    step("overflow_write", 1'b0, 1'b1, rand_tile(), '0, 1'b1);
    drain("drain_full");

    step("rst_a", 1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 3; n++) step("fill3", 1'b0, 1'b1, rand_tile(), '0, 1'b0);
    for (int n = 0; n < 3; n++) step("pop_lane0", 1'b0, 1'b0, '0, 2'b01, 1'b1);
    expect_bit("lane0_empty_valid", bus.pe2row_data_valid, 1'b0);
    step("pop_both_underflow", 1'b0, 1'b0, '0, 2'b11, 1'b1);
    step("rden_not_ready", 1'b0, 1'b0, '0, 2'b11, 1'b0);
    drain("drain_lane1");

    step("rst_b", 1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < DEPTH; n++) step("fill_b", 1'b0, 1'b1, rand_tile(), '0, 1'b0);
    step("full_wr_and_pop", 1'b0, 1'b1, rand_tile(), 2'b11, 1'b1);
    expect_bit("full_cleared_by_pop", bus.pe_full, 1'b0);
    step("write_after_pop", 1'b0, 1'b1, rand_tile(), '0, 1'b0);
    expect_bit("full_again", bus.pe_full, 1'b1);
    drain("drain_b");

    step("rst_c", 1'b1, 1'b0, '0, '0, 1'b0);
    for (int n = 0; n < 40; n++) step("stream", 1'b0, 1'b1, rand_tile(), 2'b11, 1'b1);
    drain("drain_stream");

    for (int n = 0; n < 9; n++) step("fill9", 1'b0, 1'b1, rand_tile(), '0, 1'b0);
    step("mid_reset", 1'b1, 1'b1, rand_tile(), 2'b11, 1'b1);
    expect_bit("mid_reset_valid", bus.pe2row_data_valid, 1'b0);
    step("post_reset_write", 1'b0, 1'b1, seq_tile(40, 90), '0, 1'b0);

    for (int n = 0; n < 400; n++)
      step("random", 1'b0, ($urandom_range(0, 99) < 60), rand_tile(),
           WH'($urandom), ($urandom_range(0, 3) != 0));
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
